// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//
// Read-side engine for a simple dual-port BRAM. A (base, length) command is
// accepted in idle. The engine issues sequential reads, covers the fixed BRAM
// read latency, and returns the words as a valid/ready stream with a last flag.
// A small credit-limited FIFO buffers the words, so the consumer can stall at
// any time and no word is lost. With no stalls the stream runs at one word
// per cycle.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_start           command strobe, sampled only in idle
//   i_base_addr       first word address, captured on an accepted start
//   i_length          word count 0..2^ADDR_WIDTH, captured on an accepted start
//   o_busy            high from the cycle after an accepted start until done
//   o_done            one-cycle completion pulse
//   o_rd_addr/o_rd_en BRAM read address / enable
//   o_rd_regce        BRAM output register enable (rd_en delayed one cycle)
//   o_rd_rst          BRAM output register reset (follows i_rst)
//   i_rd_data         BRAM read data
//   o_out_data        stream data (FIFO head)
//   o_out_valid       stream valid
//   i_out_ready       stream ready
//   o_out_last        final word of the command, qualified by o_out_valid

module bram_stream_reader #(
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned ADDR_WIDTH   = 9,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH:0]   i_length,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rd_addr,
  output logic                  o_rd_en,
  output logic                  o_rd_regce,
  output logic                  o_rd_rst,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic [DATA_WIDTH-1:0] o_out_data,
  output logic                  o_out_valid,
  input  logic                  i_out_ready,
  output logic                  o_out_last
);

  localparam int unsigned LenW = ADDR_WIDTH + 1;
  // Wide enough to hold fifo_count + inflight without overflow.
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + READ_LATENCY + 1) + 1;
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrMaxC = PtrW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain,
    StDone
  } state_e;

  state_e r_state;
  state_e w_state_next;

  // Command registers
  logic [ADDR_WIDTH-1:0] r_base;
  logic [LenW-1:0]       r_len;
  logic [LenW-1:0]       r_issued;

  // In-flight tracking, one stage per cycle of BRAM latency
  logic [READ_LATENCY-1:0] r_pipe_vld;
  logic [READ_LATENCY-1:0] r_pipe_last;

  // Output FIFO
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [PtrW-1:0]       r_wptr;
  logic [PtrW-1:0]       r_rptr;
  logic [CntW-1:0]       r_fifo_cnt;

  logic r_regce;
  logic r_done;

  logic [CntW-1:0] w_inflight;
  logic            w_credit_ok;
  logic            w_more;
  logic            w_rd_en;
  logic            w_issue_last;
  logic            w_push;
  logic            w_push_last;
  logic            w_pop;
  logic            w_fifo_valid;
  logic            w_head_last;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrMaxC) ? '0 : p + PtrW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < int'(READ_LATENCY); i++) begin
      w_inflight = w_inflight + {{(CntW-1){1'b0}}, r_pipe_vld[i]};
    end
  end

  // Same-cycle pops are ignored here, so the credit check is conservative.
  assign w_credit_ok  = (r_fifo_cnt + w_inflight) < DepthC;
  assign w_more       = r_issued < r_len;
  assign w_issue_last = (r_issued == (r_len - LenW'(1)));

  assign w_push       = r_pipe_vld[READ_LATENCY-1];
  assign w_push_last  = r_pipe_last[READ_LATENCY-1];
  assign w_fifo_valid = (r_fifo_cnt != '0);
  assign w_pop        = w_fifo_valid & i_out_ready;
  assign w_head_last  = r_fifo_last[r_rptr];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // done trails the DONE state by one cycle.
      r_done  <= (r_state == StDone);
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_next = (i_length == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (!w_more) begin
          w_state_next = StDrain;
        end
      end
      StDrain: begin
        if (w_pop && w_head_last) begin
          w_state_next = StDone;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------

  always_comb begin
    o_busy  = (r_state != StIdle);
    w_rd_en = (r_state == StRun) && w_more && w_credit_ok;
  end

  // ---------------------------------------------------------------------------
  // Command capture and issue counter
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_base   <= '0;
      r_len    <= '0;
      r_issued <= '0;
    end else if ((r_state == StIdle) && i_start) begin
      r_base   <= i_base_addr;
      r_len    <= i_length;
      r_issued <= '0;
    end else if (w_rd_en) begin
      r_issued <= r_issued + LenW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight shift register and BRAM register enable
  // ---------------------------------------------------------------------------

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe_vld  <= '0;
      r_pipe_last <= '0;
      r_regce     <= 1'b0;
    end else begin
      r_pipe_vld[0]  <= w_rd_en;
      r_pipe_last[0] <= w_rd_en & w_issue_last;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
        r_pipe_vld[i]  <= r_pipe_vld[i-1];
        r_pipe_last[i] <= r_pipe_last[i-1];
      end
      r_regce <= w_rd_en;
    end
  end

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------

  // Storage is not reset. Its contents are masked by the count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo_data[r_wptr] <= i_rd_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fifo_last <= '0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_fifo_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_last[r_wptr] <= w_push_last;
        r_wptr              <= ptr_inc(r_wptr);
      end
      if (w_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + CntW'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - CntW'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Port assignments
  // ---------------------------------------------------------------------------

  assign o_done      = r_done;
  assign o_rd_en     = w_rd_en;
  assign o_rd_addr   = r_base + r_issued[ADDR_WIDTH-1:0];
  assign o_rd_regce  = r_regce;
  assign o_rd_rst    = i_rst;
  assign o_out_valid = w_fifo_valid;
  // Zero the data and last outputs when nothing is buffered, so no stale word is visible.
  assign o_out_data  = w_fifo_valid ? r_fifo_data[r_rptr] : '0;
  assign o_out_last  = w_fifo_valid & w_head_last;

endmodule
